// File: rtl/main_control_unit.sv
// Main opcode decoder for the single-cycle MIPS-subset core; all strobes registered (1-cycle latency).
// Optional build macro CTRL_ILLEGAL_OP_EN adds a registered illegal_op flag.
module main_control_unit (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] opcode,
    output logic       RegDst,
    output logic       Jump,
    output logic       Branch,
    output logic       MemRead,
    output logic       MemToReg,
    output logic [3:0] ALUOp,
    output logic       MemWrite,
    output logic       ALUSrc,
    output logic       RegWrite,
    output logic       PCSrc
`ifdef CTRL_ILLEGAL_OP_EN
    ,
    output logic       illegal_op
`endif
);

    // Control word layout: RegDst Jump Branch MemRead MemToReg ALUOp[3:0] MemWrite ALUSrc RegWrite PCSrc
    logic [12:0] ctrl_d;
    logic [12:0] ctrl_q;
`ifdef CTRL_ILLEGAL_OP_EN
    logic        illegal_d;
    logic        illegal_q;
`endif

    always_comb begin
        ctrl_d = 13'b0;
`ifdef CTRL_ILLEGAL_OP_EN
        illegal_d = 1'b0;
`endif
        case (opcode)
            6'b000000: ctrl_d = 13'b1_0_0_0_0_0010_0_0_1_0; // R-type
            6'b000010: ctrl_d = 13'b0_1_0_0_0_0000_0_0_0_1; // j
            6'b000011: ctrl_d = 13'b0_1_0_0_0_0000_0_0_1_1; // jal
            6'b000100: ctrl_d = 13'b0_0_1_0_0_0001_0_0_0_0; // beq
            6'b000101: ctrl_d = 13'b0_0_1_0_0_0111_0_0_0_0; // bne
            6'b001000: ctrl_d = 13'b0_0_0_0_0_0000_0_1_1_0; // addi
            6'b001010: ctrl_d = 13'b0_0_0_0_0_0110_0_1_1_0; // slti
            6'b001100: ctrl_d = 13'b0_0_0_0_0_0011_0_1_1_0; // andi
            6'b001101: ctrl_d = 13'b0_0_0_0_0_0100_0_1_1_0; // ori
            6'b001110: ctrl_d = 13'b0_0_0_0_0_0101_0_1_1_0; // xori
            6'b100011: ctrl_d = 13'b0_0_0_1_1_0000_0_1_1_0; // lw
            6'b101011: ctrl_d = 13'b0_0_0_0_0_0000_1_1_0_0; // sw
            default: begin
                // Unknown opcode decodes as a NOP: no writes, no redirect.
                ctrl_d = 13'b0;
`ifdef CTRL_ILLEGAL_OP_EN
                illegal_d = 1'b1;
`endif
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ctrl_q <= 13'b0;
`ifdef CTRL_ILLEGAL_OP_EN
            illegal_q <= 1'b0;
`endif
        end else begin
            ctrl_q <= ctrl_d;
`ifdef CTRL_ILLEGAL_OP_EN
            illegal_q <= illegal_d;
`endif
        end
    end

    assign RegDst   = ctrl_q[12];
    assign Jump     = ctrl_q[11];
    assign Branch   = ctrl_q[10];
    assign MemRead  = ctrl_q[9];
    assign MemToReg = ctrl_q[8];
    assign ALUOp    = ctrl_q[7:4];
    assign MemWrite = ctrl_q[3];
    assign ALUSrc   = ctrl_q[2];
    assign RegWrite = ctrl_q[1];
    assign PCSrc    = ctrl_q[0];
`ifdef CTRL_ILLEGAL_OP_EN
    assign illegal_op = illegal_q;
`endif

endmodule

// File: tb/tb_main_control_unit.sv
// Randomized self-checking bench for main_control_unit against an instruction-semantics model.
module tb_main_control_unit;

    logic       clk;
    logic       reset;
    logic [5:0] opcode;
    logic       RegDst, Jump, Branch, MemRead, MemToReg, MemWrite, ALUSrc, RegWrite, PCSrc;
    logic [3:0] ALUOp;
`ifdef CTRL_ILLEGAL_OP_EN
    logic       illegal_op;
`endif

    int checks = 0;
    int failures = 0;

    main_control_unit dut (
        .clk      (clk),
        .reset    (reset),
        .opcode   (opcode),
        .RegDst   (RegDst),
        .Jump     (Jump),
        .Branch   (Branch),
        .MemRead  (MemRead),
        .MemToReg (MemToReg),
        .ALUOp    (ALUOp),
        .MemWrite (MemWrite),
        .ALUSrc   (ALUSrc),
        .RegWrite (RegWrite),
        .PCSrc    (PCSrc)
`ifdef CTRL_ILLEGAL_OP_EN
        ,
        .illegal_op (illegal_op)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Model: derive each strobe from what the instruction does.
    function automatic logic [12:0] model(input logic [5:0] op);
        logic r, j, jal, beq, bne, addi, slti, andi, ori, xori, lw, sw, imm, jmp;
        logic [3:0] alu;
        r = (op == 6'd0);   j = (op == 6'd2);    jal = (op == 6'd3);
        beq = (op == 6'd4); bne = (op == 6'd5);  addi = (op == 6'd8);
        slti = (op == 6'd10); andi = (op == 6'd12); ori = (op == 6'd13);
        xori = (op == 6'd14); lw = (op == 6'd35); sw = (op == 6'd43);
        imm = addi | slti | andi | ori | xori;
        jmp = j | jal;
        if (r)         alu = 4'd2;
        else if (beq)  alu = 4'd1;
        else if (bne)  alu = 4'd7;
        else if (andi) alu = 4'd3;
        else if (ori)  alu = 4'd4;
        else if (xori) alu = 4'd5;
        else if (slti) alu = 4'd6;
        else           alu = 4'd0;
        return {r, jmp, beq | bne, lw, lw, alu, sw, imm | lw | sw, r | jal | imm | lw, jmp};
    endfunction

    function automatic logic model_illegal(input logic [5:0] op);
        return (model(op) == 13'b0) && (op != 6'd2);
    endfunction

    function automatic logic [12:0] observed();
        return {RegDst, Jump, Branch, MemRead, MemToReg, ALUOp, MemWrite, ALUSrc, RegWrite, PCSrc};
    endfunction

    // Apply inputs at a falling edge, let one rising edge pass, check at the next falling edge.
    task automatic step(input string tag, input logic r, input logic [5:0] op);
        logic [12:0] exp;
        reset  = r;
        opcode = op;
        @(negedge clk);
        exp = r ? 13'b0 : model(op);
        check(tag, {19'b0, observed()}, {19'b0, exp});
`ifdef CTRL_ILLEGAL_OP_EN
        check({tag, "_ill"}, {31'b0, illegal_op}, {31'b0, !r && model_illegal(op)});
`endif
    endtask

    initial begin
        logic [5:0] sweep [12];
        logic [12:0] sw_row;
        sweep = '{6'd0, 6'd8, 6'd12, 6'd13, 6'd14, 6'd4, 6'd5, 6'd10, 6'd35, 6'd43, 6'd2, 6'd3};

        reset = 1'b1;
        opcode = 6'd0;
        @(negedge clk);
        step("reset", 1'b1, 6'd0);
        step("rtype_after_reset", 1'b0, 6'd0);
        check("rtype_row", {19'b0, observed()}, {19'b0, 13'b1_0_0_0_0_0010_0_0_1_0});

        foreach (sweep[i]) step($sformatf("sweep_op%0d", sweep[i]), 1'b0, sweep[i]);
        step("lw_row", 1'b0, 6'd35);
        check("lw_fixed", {19'b0, observed()}, {19'b0, 13'b0_0_0_1_1_0000_0_1_1_0});

        // Latency: opcode change mid-cycle must not show before the next rising edge.
        step("sw", 1'b0, 6'd43);
        sw_row = model(6'd43);
        opcode = 6'd2;
        #2;
        check("latency_hold", {19'b0, observed()}, {19'b0, sw_row});
        @(negedge clk);
        check("latency_j", {19'b0, observed()}, {19'b0, model(6'd2)});
        check("latency_j_fixed", {19'b0, observed()}, {19'b0, 13'b0_1_0_0_0_0000_0_0_0_1});

        step("illegal_3f", 1'b0, 6'h3f);
        step("back_to_lw", 1'b0, 6'd35);

        step("jal", 1'b0, 6'd3);
        step("reset_mid", 1'b1, 6'd3);
        step("jal_restore", 1'b0, 6'd3);

        for (int n = 0; n < 1000; n++) begin
            logic [5:0] op;
            logic r;
            op = (($urandom % 2) == 0) ? sweep[$urandom_range(0, 11)] : 6'($urandom);
            r  = ($urandom_range(0, 31) == 0);
            step("random", r, op);
            check("inv_memrw", {31'b0, MemRead & MemWrite}, 32'd0);
            check("inv_pcsrc", {31'b0, PCSrc}, {31'b0, Jump});
            check("inv_memtoreg", {31'b0, MemToReg & ~MemRead}, 32'd0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
